bram_input_arbiter: RTL and testbench

BRAM_INPUT_ARBITER -- requirements
Module: bram_input_arbiter

---
 rtl/bram_input_arbiter_pkg.sv | 21 ++
 rtl/arb_in_fifo.sv | 55 +++++
 rtl/bram_input_arbiter.sv | 136 +++++++++++++
 tb/tb_bram_input_arbiter.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_input_arbiter_pkg.sv
// Shared types and constants for the BRAM input arbiter.
package bram_input_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_e;

  localparam int CNTR_W = 32;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_in_fifo.sv
// Fall-through FIFO: the head word is visible on dout_o whenever not empty.
module arb_in_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
  logic                wr_ok, rd_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                   (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
  assign wr_ok   = wr_en_i & ~full_o;
  assign rd_ok   = rd_en_i & ~empty_o;
  assign dout_o  = mem[rd_ptr_q[DEPTH_BITS-1:0]];

  // Next pointer values; read and write may both advance in one cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr_q[DEPTH_BITS-1:0]] <= din_i;
  end

endmodule

// File: rtl/bram_input_arbiter.sv
// Merges NUM_QUEUES AXI-Stream inputs into one output, whole packets at a
// time, with round-robin grant and per-port forwarded-packet counters.
module bram_input_arbiter
  import bram_input_arbiter_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_QUEUES           = 5,
  parameter int FIFO_DEPTH_BITS      = 4
) (
  input  logic                                          axi_aclk,
  input  logic                                          axi_resetn,
  input  logic [NUM_QUEUES*C_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [NUM_QUEUES*C_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
  input  logic [NUM_QUEUES*C_S_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic [NUM_QUEUES-1:0]                         s_axis_tvalid,
  input  logic [NUM_QUEUES-1:0]                         s_axis_tlast,
  output logic [NUM_QUEUES-1:0]                         s_axis_tready,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]              m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
  output logic                                          m_axis_tvalid,
  output logic                                          m_axis_tlast,
  input  logic                                          m_axis_tready,
  input  logic                                          rst_cntrs,
  output logic [NUM_QUEUES*CNTR_W-1:0]                  pkt_fwd_cntr
);

  localparam int DW     = C_S_AXIS_DATA_WIDTH;
  localparam int SW     = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW     = C_S_AXIS_TUSER_WIDTH;
  localparam int WORD_W = DW + SW + UW + 1;
  localparam int PTR_W  = (NUM_QUEUES > 1) ? clog2(NUM_QUEUES) : 1;

  arb_state_e       state_q, state_d;
  logic [PTR_W-1:0] sel_q, sel_d;
  logic [PTR_W-1:0] last_grant_q, last_grant_d;

  logic [WORD_W-1:0]     head [NUM_QUEUES];
  logic [WORD_W-1:0]     sel_word;
  logic [NUM_QUEUES-1:0] full, empty, pop, inc;
  logic                  head_last;
  logic                  pop_any;
  logic                  found;
  logic [PTR_W-1:0]      idx;

  assign sel_word = head[sel_q];
  assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, head_last} = sel_word;
  assign m_axis_tvalid = (state_q == SEND) && !empty[sel_q];
  assign m_axis_tlast  = m_axis_tvalid & head_last;

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_port
    logic [WORD_W-1:0] wr_word;
    logic [CNTR_W-1:0] cnt_q, cnt_d;

    assign wr_word = {s_axis_tdata[i*DW +: DW], s_axis_tstrb[i*SW +: SW],
                      s_axis_tuser[i*UW +: UW], s_axis_tlast[i]};
    assign s_axis_tready[i] = axi_resetn & ~full[i];
    assign pop[i] = pop_any && (sel_q == PTR_W'(i));
    assign inc[i] = pop[i] & head_last;
    assign pkt_fwd_cntr[i*CNTR_W +: CNTR_W] = cnt_q;

    arb_in_fifo #(
      .WIDTH      (WORD_W),
      .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
      .clk_i   (axi_aclk),
      .rst_ni  (axi_resetn),
      .wr_en_i (s_axis_tvalid[i] & s_axis_tready[i]),
      .din_i   (wr_word),
      .rd_en_i (pop[i]),
      .dout_o  (head[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );

    // Counter clear wins over a same-cycle packet completion; wraps at 2^32.
    always_comb begin
      cnt_d = cnt_q;
      if (rst_cntrs)   cnt_d = '0;
      else if (inc[i]) cnt_d = cnt_q + 1'b1;
    end

    // Forwarded-packet counter register.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) cnt_q <= '0;
      else             cnt_q <= cnt_d;
    end
  end

  // Grant search in IDLE, packet forwarding in SEND; grant moves only on tlast.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    pop_any      = 1'b0;
    found        = 1'b0;
    idx          = '0;
    case (state_q)
      IDLE: begin
        for (int k = 1; k <= NUM_QUEUES; k++) begin
          idx = PTR_W'((int'(last_grant_q) + k) % NUM_QUEUES);
          if (!found && !empty[idx]) begin
            found = 1'b1;
            sel_d = idx;
          end
        end
        if (found) state_d = SEND;
      end
      SEND: begin
        pop_any = m_axis_tvalid & m_axis_tready;
        if (pop_any && head_last) begin
          last_grant_d = sel_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM registers; reset points the grant at the last port so port 0 wins first.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      last_grant_q <= PTR_W'(NUM_QUEUES - 1);
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_bram_input_arbiter.sv
// Directed bench for bram_input_arbiter.
module tb_bram_input_arbiter;

  localparam int NQ = 5;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam int UW = 128;

  logic              clk;
  logic              axi_resetn;
  logic [NQ*DW-1:0]  s_axis_tdata;
  logic [NQ*SW-1:0]  s_axis_tstrb;
  logic [NQ*UW-1:0]  s_axis_tuser;
  logic [NQ-1:0]     s_axis_tvalid;
  logic [NQ-1:0]     s_axis_tlast;
  logic [NQ-1:0]     s_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [SW-1:0]     m_axis_tstrb;
  logic [UW-1:0]     m_axis_tuser;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic              rst_cntrs;
  logic [NQ*32-1:0]  pkt_fwd_cntr;

  logic [DW-1:0] din [NQ];
  logic [UW-1:0] usr [NQ];
  logic [SW-1:0] stb [NQ];
  logic          lst [NQ];
  logic [NQ-1:0] vld;

  typedef struct {
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [SW-1:0] s;
    logic          l;
    int            c;
  } obs_t;

  obs_t obs_q[$];
  obs_t mon_o;
  int   cyc;
  int   vectors;
  int   miscompares;

  bram_input_arbiter dut (
    .axi_aclk      (clk),
    .axi_resetn    (axi_resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .rst_cntrs     (rst_cntrs),
    .pkt_fwd_cntr  (pkt_fwd_cntr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = '0;
    s_axis_tvalid = vld;
    for (int p = 0; p < NQ; p++) begin
      s_axis_tdata[p*DW +: DW] = din[p];
      s_axis_tstrb[p*SW +: SW] = stb[p];
      s_axis_tuser[p*UW +: UW] = usr[p];
      s_axis_tlast[p]          = lst[p];
    end
  end

  // Output monitor: records every accepted word with its cycle number.
  always @(negedge clk) begin
    if (axi_resetn && m_axis_tvalid && m_axis_tready) begin
      mon_o.d = m_axis_tdata;
      mon_o.u = m_axis_tuser;
      mon_o.s = m_axis_tstrb;
      mon_o.l = m_axis_tlast;
      mon_o.c = cyc;
      obs_q.push_back(mon_o);
    end
  end

  function automatic logic [DW-1:0] mkd(input int p, input int k);
    logic [DW-1:0] r;
    r = '0;
    r[DW-1:DW-16] = 16'hC0DE;
    r[15:8] = 8'(p);
    r[7:0]  = 8'(k);
    return r;
  endfunction

  function automatic logic [UW-1:0] mku(input int p, input int k);
    logic [UW-1:0] r;
    r = '0;
    r[UW-1:UW-8] = 8'hA5;
    r[23:16] = 8'(k);
    r[11:4]  = 8'(p);
    return r;
  endfunction

  function automatic logic [SW-1:0] mks(input int p, input int k);
    return 32'h8000_0001 ^ 32'((p << 12) | (k << 4));
  endfunction

  task tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int p, input int k, input logic last);
    din[p] = mkd(p, k);
    usr[p] = mku(p, k);
    stb[p] = mks(p, k);
    lst[p] = last;
  endtask

  // Offer one word on port p and hold it until the DUT accepts it.
  task automatic push(input int p, input int k, input logic last);
    logic r;
    int   t;
    set_word(p, k, last);
    vld[p] = 1'b1;
    r = 1'b0;
    t = 0;
    while (!r && t < 200) begin
      @(negedge clk);
      r = s_axis_tready[p];
      @(posedge clk);
      #1;
      t++;
    end
    vld[p] = 1'b0;
    if (!r) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout port %0d word %0d: tready stayed 0, required 1", p, k);
    end
  endtask

  // One write cycle on every port in mask (FIFOs assumed not full).
  task automatic push_all(input logic [NQ-1:0] mask, input int k, input logic last);
    for (int p = 0; p < NQ; p++) if (mask[p]) set_word(p, k, last);
    vld = mask;
    tick();
    vld = '0;
  endtask

  task automatic wait_obs(input int n, input string nm);
    int t;
    t = 0;
    while (obs_q.size() < n && t < 300) begin
      tick();
      t++;
    end
    vectors++;
    if (obs_q.size() < n) begin
      miscompares++;
      $display("FAIL %s: got %0d output words, required %0d", nm, obs_q.size(), n);
    end
  endtask

  task automatic reset_dut;
    axi_resetn = 1'b0;
    vld = '0;
    repeat (2) tick();
    axi_resetn = 1'b1;
    tick();
    obs_q.delete();
  endtask

  task automatic test_reset;
    axi_resetn = 1'b0;
    #1;
    vectors++;
    if (s_axis_tready !== 5'h00) begin miscompares++; $display("FAIL rst_s_tready: got %b required 00000", s_axis_tready); end
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_m_tvalid: got %b required 0", m_axis_tvalid); end
    vectors++;
    if (m_axis_tlast !== 1'b0) begin miscompares++; $display("FAIL rst_m_tlast: got %b required 0", m_axis_tlast); end
    vectors++;
    if (pkt_fwd_cntr !== '0) begin miscompares++; $display("FAIL rst_cntr: got %h required 0", pkt_fwd_cntr); end
    tick();
    axi_resetn = 1'b1;
    tick();
    vectors++;
    if (s_axis_tready !== 5'h1F) begin miscompares++; $display("FAIL post_rst_s_tready: got %b required 11111", s_axis_tready); end
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL post_rst_m_tvalid: got %b required 0", m_axis_tvalid); end
  endtask

  task automatic test_single;
    logic [NQ*32-1:0] exp_c;
    obs_q.delete();
    m_axis_tready = 1'b1;
    push(2, 0, 1'b0);
    push(2, 1, 1'b0);
    push(2, 2, 1'b1);
    wait_obs(3, "single_count");
    repeat (3) tick();
    for (int j = 0; j < 3; j++) begin
      vectors++;
      if (j >= obs_q.size() || obs_q[j].d !== mkd(2, j)) begin
        miscompares++;
        $display("FAIL single_data[%0d]: got %h required %h", j, (j < obs_q.size()) ? obs_q[j].d : '0, mkd(2, j));
      end
      vectors++;
      if (j >= obs_q.size() || obs_q[j].l !== (j == 2)) begin
        miscompares++;
        $display("FAIL single_last[%0d]: got %b required %b", j, (j < obs_q.size()) ? obs_q[j].l : 1'bx, (j == 2));
      end
    end
    vectors++;
    if (obs_q.size() < 2 || obs_q[1].u !== mku(2, 1) || obs_q[1].s !== mks(2, 1)) begin
      miscompares++;
      $display("FAIL single_user_strb: got %h/%h required %h/%h", (obs_q.size() > 1) ? obs_q[1].u : '0,
               (obs_q.size() > 1) ? obs_q[1].s : '0, mku(2, 1), mks(2, 1));
    end
    exp_c = '0;
    exp_c[2*32 +: 32] = 32'd1;
    vectors++;
    if (pkt_fwd_cntr !== exp_c) begin miscompares++; $display("FAIL single_cntr: got %h required %h", pkt_fwd_cntr, exp_c); end
  endtask

  task automatic test_round_robin;
    reset_dut();
    m_axis_tready = 1'b0;
    push_all(5'h1F, 0, 1'b0);
    push_all(5'h1F, 1, 1'b1);
    m_axis_tready = 1'b1;
    wait_obs(10, "rr_count");
    for (int j = 0; j < 10; j++) begin
      vectors++;
      if (j >= obs_q.size() || obs_q[j].d !== mkd(j / 2, j % 2) || obs_q[j].l !== (j % 2 == 1)) begin
        miscompares++;
        $display("FAIL rr_order[%0d]: got %h required %h", j, (j < obs_q.size()) ? obs_q[j].d : '0, mkd(j / 2, j % 2));
      end
    end
    for (int p = 1; p < NQ; p++) begin
      vectors++;
      if (obs_q.size() < 10 || obs_q[2*p].c - obs_q[2*p-1].c != 2) begin
        miscompares++;
        $display("FAIL rr_gap[%0d]: got %0d cycles required 2", p, (obs_q.size() >= 10) ? obs_q[2*p].c - obs_q[2*p-1].c : -1);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] held;
    obs_q.delete();
    m_axis_tready = 1'b0;
    for (int k = 0; k < 15; k++) push(1, k, 1'b0);
    vectors++;
    if (s_axis_tready[1] !== 1'b1) begin miscompares++; $display("FAIL bp_ready15: got %b required 1", s_axis_tready[1]); end
    push(1, 15, 1'b0);
    vectors++;
    if (s_axis_tready[1] !== 1'b0) begin miscompares++; $display("FAIL bp_ready16: got %b required 0", s_axis_tready[1]); end
    held = m_axis_tdata;
    vectors++;
    if (m_axis_tvalid !== 1'b1 || held !== mkd(1, 0)) begin
      miscompares++;
      $display("FAIL bp_head: got v=%b %h required v=1 %h", m_axis_tvalid, held, mkd(1, 0));
    end
    repeat (3) tick();
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== mkd(1, 0)) begin
      miscompares++;
      $display("FAIL bp_stable: got v=%b %h required v=1 %h", m_axis_tvalid, m_axis_tdata, mkd(1, 0));
    end
    m_axis_tready = 1'b1;
    for (int k = 16; k < 20; k++) push(1, k, k == 19);
    wait_obs(20, "bp_count");
    for (int j = 0; j < 20; j++) begin
      vectors++;
      if (j >= obs_q.size() || obs_q[j].d !== mkd(1, j) || obs_q[j].l !== (j == 19)) begin
        miscompares++;
        $display("FAIL bp_word[%0d]: got %h required %h", j, (j < obs_q.size()) ? obs_q[j].d : '0, mkd(1, j));
      end
    end
  endtask

  task automatic test_no_interleave;
    int bad;
    int ep[5] = '{0, 0, 0, 3, 3};
    int ek[5] = '{0, 1, 2, 0, 1};
    obs_q.delete();
    m_axis_tready = 1'b1;
    push(0, 0, 1'b0);
    push(0, 1, 1'b0);
    push(3, 0, 1'b0);
    push(3, 1, 1'b1);
    bad = 0;
    repeat (4) begin
      tick();
      if (m_axis_tvalid !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0 || obs_q.size() != 2) begin
      miscompares++;
      $display("FAIL starve: got %0d words, %0d valid cycles; required 2 words, 0 valid cycles", obs_q.size(), bad);
    end
    push(0, 2, 1'b1);
    wait_obs(5, "ni_count");
    for (int j = 0; j < 5; j++) begin
      vectors++;
      if (j >= obs_q.size() || obs_q[j].d !== mkd(ep[j], ek[j]) || obs_q[j].l !== (j == 2 || j == 4)) begin
        miscompares++;
        $display("FAIL ni_word[%0d]: got %h required %h", j, (j < obs_q.size()) ? obs_q[j].d : '0, mkd(ep[j], ek[j]));
      end
    end
  endtask

  task automatic test_counters;
    int t;
    force dut.g_port[4].cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.g_port[4].cnt_q;
    vectors++;
    if (pkt_fwd_cntr[4*32 +: 32] !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL cntr_preload: got %h required ffffffff", pkt_fwd_cntr[4*32 +: 32]);
    end
    obs_q.delete();
    m_axis_tready = 1'b1;
    push(4, 7, 1'b1);
    wait_obs(1, "wrap_count");
    repeat (2) tick();
    vectors++;
    if (pkt_fwd_cntr[4*32 +: 32] !== 32'h0) begin
      miscompares++;
      $display("FAIL cntr_wrap: got %h required 00000000", pkt_fwd_cntr[4*32 +: 32]);
    end
    m_axis_tready = 1'b0;
    push(2, 9, 1'b1);
    t = 0;
    while (m_axis_tvalid !== 1'b1 && t < 50) begin tick(); t++; end
    vectors++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_pending: got v=%b l=%b required v=1 l=1", m_axis_tvalid, m_axis_tlast);
    end
    m_axis_tready = 1'b1;
    rst_cntrs = 1'b1;
    tick();
    rst_cntrs = 1'b0;
    tick();
    vectors++;
    if (pkt_fwd_cntr !== '0) begin miscompares++; $display("FAIL clr_priority: got %h required 0", pkt_fwd_cntr); end
    vectors++;
    if (obs_q.size() != 2 || obs_q[1].d !== mkd(2, 9)) begin
      miscompares++;
      $display("FAIL clr_word: got %0d words, required 2 ending in %h", obs_q.size(), mkd(2, 9));
    end
  endtask

  task automatic test_reset_mid;
    int t;
    obs_q.delete();
    m_axis_tready = 1'b0;
    push(2, 0, 1'b0);
    push(2, 1, 1'b0);
    t = 0;
    while (m_axis_tvalid !== 1'b1 && t < 50) begin tick(); t++; end
    axi_resetn = 1'b0;
    #1;
    vectors++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_rst_out: got v=%b l=%b required 0 0", m_axis_tvalid, m_axis_tlast);
    end
    vectors++;
    if (s_axis_tready !== 5'h00 || pkt_fwd_cntr !== '0) begin
      miscompares++;
      $display("FAIL mid_rst_in: got tready=%b cntr=%h required 0 0", s_axis_tready, pkt_fwd_cntr);
    end
    repeat (2) tick();
    axi_resetn = 1'b1;
    tick();
    m_axis_tready = 1'b1;
    push(0, 4, 1'b0);
    push(0, 5, 1'b1);
    wait_obs(2, "post_rst_count");
    repeat (6) tick();
    vectors++;
    if (obs_q.size() != 2) begin miscompares++; $display("FAIL post_rst_residue: got %0d words required 2", obs_q.size()); end
    for (int j = 0; j < 2; j++) begin
      vectors++;
      if (j >= obs_q.size() || obs_q[j].d !== mkd(0, 4 + j) || obs_q[j].l !== (j == 1)) begin
        miscompares++;
        $display("FAIL post_rst_word[%0d]: got %h required %h", j, (j < obs_q.size()) ? obs_q[j].d : '0, mkd(0, 4 + j));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    cyc           = 0;
    axi_resetn    = 1'b0;
    m_axis_tready = 1'b0;
    rst_cntrs     = 1'b0;
    vld           = '0;
    for (int p = 0; p < NQ; p++) begin
      din[p] = '0;
      usr[p] = '0;
      stb[p] = '0;
      lst[p] = 1'b0;
    end
    repeat (2) tick();
    axi_resetn = 1'b1;
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_no_interleave();
    test_counters();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
